// File: rtl/lab1_op_pkg.sv
// Shared types and the golden opcode model for the 2-bit logic unit driver.
// The golden function is only used by the driver when LAB1_OP_CHECK_EN is defined.
package lab1_op_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_XNOR = 2'd1;
   localparam logic [1:0] OP_OR   = 2'd2;
   localparam logic [1:0] OP_NOTA = 2'd3;

   // Widest operand the golden function handles; callers cast up and slice down.
   localparam int LAB1_GOLD_W = 8;

   function automatic logic [LAB1_GOLD_W-1:0] lab1_golden(
      input logic [LAB1_GOLD_W-1:0] a,
      input logic [LAB1_GOLD_W-1:0] b,
      input logic [1:0]             sel
   );
      logic [LAB1_GOLD_W-1:0] f;
      case (sel)
         OP_AND:  f = a & b;
         OP_XNOR: f = ~(a ^ b);
         OP_OR:   f = a | b;
         default: f = ~a;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/lab1_op_driver.sv
// Request/response front end for the combinational 2-bit logic unit.
// Optional golden-model checking (rsp_err, err_cnt) is built when LAB1_OP_CHECK_EN is defined.
module lab1_op_driver
   import lab1_op_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_f,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f
`ifdef LAB1_OP_CHECK_EN
   ,
   output logic             rsp_err,
   output logic [7:0]       err_cnt
`endif
);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic       accept;
   logic       capture;
   logic       rsp_done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; handshakes are qualified by state so stray req/rsp activity is ignored
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // Operand registers hold the last command after the response until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         cnt     <= '0;
         rsp_f   <= '0;
      end else begin
         if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_sel;
            cnt     <= 4'(SETTLE - 1);
         end else if (state == DRIVE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            rsp_f <= alu_f;
         end
      end
   end

`ifdef LAB1_OP_CHECK_EN
   logic [LAB1_GOLD_W-1:0] gold_full;
   logic [WIDTH-1:0]       gold_f;

   always_comb begin
      gold_full = lab1_golden(LAB1_GOLD_W'(alu_a), LAB1_GOLD_W'(alu_b), alu_sel);
      gold_f    = gold_full[WIDTH-1:0];
   end

   // Error flag travels with rsp_f; the counter only moves when the response is consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
         err_cnt <= 8'd0;
      end else begin
         if (capture) begin
            rsp_err <= (alu_f != gold_f);
         end
         if (rsp_done && rsp_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lab1_op_driver.sv
// Self-checking bench for lab1_op_driver with a behavioural logic unit attached.
// Build with LAB1_OP_CHECK_EN defined to also exercise rsp_err/err_cnt.
module tb_lab1_op_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_valid4 = 1'b0;
   logic [1:0] req_a = '0;
   logic [1:0] req_b = '0;
   logic [1:0] req_sel = '0;
   logic       rsp_ready = 1'b0;
   logic       force_zero = 1'b0;

   logic       req_ready, rsp_valid;
   logic [1:0] alu_a, alu_b, alu_sel, alu_f, rsp_f;
   logic       req_ready4, rsp_valid4;
   logic [1:0] alu_a4, alu_b4, alu_sel4, alu_f4, rsp_f4;
`ifdef LAB1_OP_CHECK_EN
   logic       rsp_err, rsp_err4;
   logic [7:0] err_cnt, err_cnt4;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Behavioural logic unit, evaluated bit by bit
   function automatic logic [1:0] unit_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel);
      logic [1:0] f;
      for (int i = 0; i < 2; i++) begin
         case (sel)
            2'd0:    f[i] = a[i] & b[i];
            2'd1:    f[i] = (a[i] == b[i]);
            2'd2:    f[i] = a[i] | b[i];
            default: f[i] = !a[i];
         endcase
      end
      return f;
   endfunction

   // Scoreboard model: per-opcode truth tables indexed by {a_bit,b_bit}
   function automatic logic [1:0] exp_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel);
      logic [3:0] tt [4];
      logic [1:0] f;
      tt[0] = 4'b1000;
      tt[1] = 4'b1001;
      tt[2] = 4'b1110;
      tt[3] = 4'b0011;
      for (int i = 0; i < 2; i++) f[i] = tt[sel][{a[i], b[i]}];
      return f;
   endfunction

   assign alu_f  = force_zero ? 2'b00 : unit_f(alu_a, alu_b, alu_sel);
   assign alu_f4 = unit_f(alu_a4, alu_b4, alu_sel4);

   lab1_op_driver #(.WIDTH(2), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f)
`ifdef LAB1_OP_CHECK_EN
      , .rsp_err(rsp_err), .err_cnt(err_cnt)
`endif
   );

   lab1_op_driver #(.WIDTH(2), .SETTLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid4), .req_ready(req_ready4),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_f(alu_f4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_f(rsp_f4)
`ifdef LAB1_OP_CHECK_EN
      , .rsp_err(rsp_err4), .err_cnt(err_cnt4)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete operation; lat counts edges after the accept edge until rsp_valid shows
   task automatic do_op(input bit use4, input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel,
                        input bit hold_rsp, output int lat, output logic [1:0] f);
      int guard = 0;
      while (!(use4 ? req_ready4 : req_ready) && guard < 50) begin
         step();
         guard++;
      end
      req_a = a;
      req_b = b;
      req_sel = sel;
      rsp_ready = 1'b0;
      if (use4) req_valid4 = 1'b1;
      else req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      req_valid4 = 1'b0;
      lat = 0;
      while (!(use4 ? rsp_valid4 : rsp_valid) && lat < 40) begin
         step();
         lat++;
      end
      f = use4 ? rsp_f4 : rsp_f;
      if (!hold_rsp) begin
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      int lat;
      logic [1:0] f;
      #3;
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 2'b00 || alu_b !== 2'b00 ||
          alu_sel !== 2'b00 || rsp_f !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL reset_init: got rdy=%b vld=%b a=%b b=%b sel=%b f=%b, want 1 0 00 00 00 00",
                  req_ready, rsp_valid, alu_a, alu_b, alu_sel, rsp_f);
      end
      step();
      rst_n = 1'b1;
      do_op(0, 2'b10, 2'b11, 2'd2, 1, lat, f);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 2'b00 || alu_b !== 2'b00 ||
          alu_sel !== 2'b00 || rsp_f !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL reset_async: got rdy=%b vld=%b a=%b b=%b sel=%b f=%b, want 1 0 00 00 00 00",
                  req_ready, rsp_valid, alu_a, alu_b, alu_sel, rsp_f);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_directed();
      logic [1:0] da [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
      logic [1:0] db [4] = '{2'b01, 2'b01, 2'b10, 2'b00};
      logic [1:0] ds [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
      logic [1:0] de [4] = '{2'b01, 2'b11, 2'b11, 2'b01};
      int lat;
      logic [1:0] f;
      for (int i = 0; i < 4; i++) begin
         do_op(0, da[i], db[i], ds[i], 0, lat, f);
         vectors++;
         if (f !== de[i] || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL directed_%0d: got f=%b lat=%0d, want f=%b lat=1", i, f, lat, de[i]);
         end
      end
   endtask

   // Every opcode x operand pair, streamed with req_valid and rsp_ready held high
   task automatic test_sweep();
      logic [1:0] q [$];
      int off = int'($urandom_range(0, 63));
      int idx = 0;
      int cyc = 0;
      int last_acc = -1;
      bit acc;
      logic [5:0] code;
      code = 6'(off);
      req_a = code[5:4];
      req_b = code[3:2];
      req_sel = code[1:0];
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      while ((idx < 64 || q.size() > 0) && cyc < 400) begin
         acc = req_valid && req_ready;
         if (rsp_valid) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL sweep_extra: got unexpected response f=%b, want none", rsp_f);
            end else begin
               if (rsp_f !== q[0]) begin
                  miscompares++;
                  $display("[TB] FAIL sweep_data: got f=%b, want %b", rsp_f, q[0]);
               end
               void'(q.pop_front());
            end
         end
         step();
         cyc++;
         if (acc) begin
            q.push_back(exp_f(req_a, req_b, req_sel));
            if (last_acc >= 0) begin
               vectors++;
               if (cyc - last_acc != 3) begin
                  miscompares++;
                  $display("[TB] FAIL sweep_rate: got %0d cycles between accepts, want 3", cyc - last_acc);
               end
            end
            last_acc = cyc;
            idx++;
            if (idx < 64) begin
               code = 6'((idx + off) % 64);
               req_a = code[5:4];
               req_b = code[3:2];
               req_sel = code[1:0];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      vectors++;
      if (idx != 64 || q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL sweep_timeout: got %0d accepted %0d pending, want 64 0", idx, q.size());
      end
      rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [1:0] f, a, b, s, e;
      a = 2'($urandom);
      b = 2'($urandom);
      s = 2'($urandom);
      e = exp_f(a, b, s);
      do_op(0, a, b, s, 1, lat, f);
      req_a = ~a;
      req_b = ~b;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_f !== e || req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_%0d: got vld=%b f=%b rdy=%b, want 1 %b 0", i, rsp_valid, rsp_f, req_ready, e);
         end
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== a || alu_b !== b || alu_sel !== s) begin
         miscompares++;
         $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b alu=%b/%b/%b, want 0 1 %b/%b/%b",
                  rsp_valid, req_ready, alu_a, alu_b, alu_sel, a, b, s);
      end
   endtask

   // Random operations with random consumer stalls; rsp_f must stay put while stalled
   task automatic test_random();
      int lat;
      logic [1:0] f, a, b, s, e;
      int stall;
      for (int n = 0; n < 20; n++) begin
         a = 2'($urandom);
         b = 2'($urandom);
         s = 2'($urandom);
         e = exp_f(a, b, s);
         stall = int'($urandom_range(0, 3));
         do_op(0, a, b, s, 1, lat, f);
         for (int k = 0; k < stall; k++) step();
         vectors++;
         if (f !== e || rsp_f !== e || rsp_valid !== 1'b1 || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL random_%0d: got f=%b held=%b vld=%b lat=%0d, want %b %b 1 1",
                     n, f, rsp_f, rsp_valid, lat, e, e);
         end
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset_in_drive();
      int lat;
      logic [1:0] f, a, b, s;
      bit seen = 0;
      a = 2'($urandom_range(1, 3));
      b = 2'($urandom);
      s = 2'($urandom);
      req_a = a;
      req_b = b;
      req_sel = s;
      req_valid4 = 1'b1;
      step();
      req_valid4 = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (rsp_valid4 !== 1'b0 || req_ready4 !== 1'b1 || alu_a4 !== 2'b00 || alu_sel4 !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL drive_reset: got vld=%b rdy=%b a=%b sel=%b, want 0 1 00 00",
                  rsp_valid4, req_ready4, alu_a4, alu_sel4);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid4) seen = 1;
         step();
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("[TB] FAIL drive_no_rsp: got rsp_valid pulse after reset, want none");
      end
      do_op(1, a, b, s, 0, lat, f);
      vectors++;
      if (f !== exp_f(a, b, s) || lat != 4) begin
         miscompares++;
         $display("[TB] FAIL drive_after: got f=%b lat=%0d, want f=%b lat=4", f, lat, exp_f(a, b, s));
      end
   endtask

`ifdef LAB1_OP_CHECK_EN
   task automatic test_check();
      int lat;
      logic [1:0] f;
      force_zero = 1'b1;
      do_op(0, 2'b01, 2'b10, 2'd2, 1, lat, f);
      vectors++;
      if (rsp_err !== 1'b1 || err_cnt !== 8'd0 || f !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL check_flag: got err=%b cnt=%0d f=%b, want 1 0 00", rsp_err, err_cnt, f);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      vectors++;
      if (err_cnt !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL check_count: got cnt=%0d, want 1", err_cnt);
      end
      force_zero = 1'b0;
      do_op(0, 2'b01, 2'b10, 2'd2, 1, lat, f);
      vectors++;
      if (rsp_err !== 1'b0 || f !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL check_clean: got err=%b f=%b, want 0 11", rsp_err, f);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      force_zero = 1'b1;
      for (int i = 0; i < 260; i++) do_op(0, 2'b01, 2'b10, 2'd2, 0, lat, f);
      force_zero = 1'b0;
      vectors++;
      if (err_cnt !== 8'd255) begin
         miscompares++;
         $display("[TB] FAIL check_saturate: got cnt=%0d, want 255", err_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_sweep();
      test_backpressure();
      test_random();
      test_reset_in_drive();
`ifdef LAB1_OP_CHECK_EN
      test_check();
`else
      $display("[TB] result check feature not built; skipping rsp_err/err_cnt scenario");
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
